ahb_mtx_l2_out_arb: RTL and testbench

// Per-output-port arbiter for the L2 AHB bus matrix: shares one output stage (slave port) between
// NUM_IN input stages. Picks the owning input port, holds ownership across fixed-length bursts and

---
 rtl/ahb_mtx_l2_pkg.sv | 46 ++++
 rtl/ahb_mtx_l2_rr_pick.sv | 38 +++
 rtl/ahb_mtx_l2_out_arb.sv | 151 +++++++++++++++
 tb/tb_ahb_mtx_l2_out_arb.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_mtx_l2_pkg.sv
// Shared definitions for the L2 AHB bus matrix: transfer/burst codes,
// output-arbiter state encoding and burst length helper.
package ahb_mtx_l2_pkg;

    localparam int PORT_W = 2;
    localparam int MAX_IN = 4;
    localparam int BEAT_W = 4;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_BURST = 2'd2,
        ST_LOCK  = 2'd3
    } arb_state_e;

    // Beats still to come after the NONSEQ of a fixed-length burst; INCR is open-ended.
    function automatic logic [BEAT_W-1:0] beats_minus1(input logic [2:0] burst);
        logic [BEAT_W-1:0] n;
        case (burst)
            HBURST_WRAP4,  HBURST_INCR4:  n = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  n = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: n = 4'd15;
            default:                      n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ahb_mtx_l2_rr_pick.sv
// Combinational masked priority picker: first requester after last_grant (round-robin)
// or lowest index (fixed priority, i.e. search always starts just after the top port).
module ahb_mtx_l2_rr_pick
    import ahb_mtx_l2_pkg::*;
#(
    parameter int NUM_IN = 3,
    parameter bit RR_EN  = 1'b1
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [PORT_W-1:0] last_grant,
    output logic [PORT_W-1:0] winner,
    output logic              any
);

    logic [MAX_IN-1:0] req_pad;
    logic [PORT_W-1:0] base;
    logic [PORT_W:0]   idx;
    logic              found;

    assign req_pad = MAX_IN'(req);
    assign any     = |req;

    always_comb begin
        base   = RR_EN ? last_grant : PORT_W'(NUM_IN - 1);
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = {1'b0, base} + 3'(k);
            if (idx >= 3'(NUM_IN)) idx = idx - 3'(NUM_IN);
            if (!found && req_pad[idx[PORT_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[PORT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ahb_mtx_l2_out_arb.sv
// Per-output-port arbiter of the L2 AHB matrix: registered owner selection with
// burst and lock hold, plus data-phase owner tracking for response routing.
module ahb_mtx_l2_out_arb
    import ahb_mtx_l2_pkg::*;
#(
    parameter int NUM_IN = 3,
    parameter bit RR_EN  = 1'b1
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic [NUM_IN-1:0]   req_i,
    input  logic [2*NUM_IN-1:0] trans_i,
    input  logic [3*NUM_IN-1:0] burst_i,
    input  logic [NUM_IN-1:0]   lock_i,
    input  logic                HREADYM,
    output logic [PORT_W-1:0]   addr_in_port,
    output logic                no_port,
    output logic [NUM_IN-1:0]   active_o,
    output logic [PORT_W-1:0]   data_in_port,
    output logic                data_valid,
    output arb_state_e          dbg_state
);

    // Handshake: HREADYM is the ready of the shared output bus. The owner's address
    // phase (its trans/burst/lock) is accepted only at an edge with HREADYM=1; with
    // HREADYM=0 nothing is accepted and every register here holds.

    arb_state_e        state_q, state_d;
    logic [PORT_W-1:0] owner_q, owner_d;
    logic [BEAT_W-1:0] cnt_q, cnt_d;
    logic [PORT_W-1:0] lg_q, lg_d;
    logic [PORT_W-1:0] dport_q, dport_d;
    logic              dvalid_q, dvalid_d;

    logic [2*MAX_IN-1:0] trans_pad;
    logic [3*MAX_IN-1:0] burst_pad;
    logic [MAX_IN-1:0]   lock_pad;
    logic [1:0]          owner_trans;
    logic [2:0]          owner_burst;
    logic                owner_lock;
    logic [PORT_W-1:0]   pick_winner;
    logic                pick_any;
    logic                locked_q, lock_d, term, hold, rearb;

    assign trans_pad = (2*MAX_IN)'(trans_i);
    assign burst_pad = (3*MAX_IN)'(burst_i);
    assign lock_pad  = MAX_IN'(lock_i);
    assign locked_q  = (state_q == ST_LOCK);

    ahb_mtx_l2_rr_pick #(
        .NUM_IN (NUM_IN),
        .RR_EN  (RR_EN)
    ) u_pick (
        .req        (req_i),
        .last_grant (lg_q),
        .winner     (pick_winner),
        .any        (pick_any)
    );

    always_comb begin
        owner_trans = '0;
        owner_burst = '0;
        owner_lock  = 1'b0;
        for (int i = 0; i < MAX_IN; i++) begin
            if (owner_q == PORT_W'(i)) begin
                owner_trans = trans_pad[2*i +: 2];
                owner_burst = burst_pad[3*i +: 3];
                owner_lock  = lock_pad[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        lg_d     = lg_q;
        dport_d  = dport_q;
        dvalid_d = dvalid_q;
        lock_d   = locked_q;
        term     = 1'b0;
        hold     = 1'b0;
        rearb    = 1'b0;
        if (HREADYM) begin
            dport_d  = owner_q;
            dvalid_d = (state_q != ST_IDLE) & owner_trans[1];
            if (state_q == ST_IDLE) begin
                rearb = 1'b1;
            end else begin
                case (owner_trans)
                    HTRANS_NONSEQ: begin
                        // A new NONSEQ inside a counted burst ends that burst early.
                        if (cnt_q != '0) begin
                            cnt_d = '0;
                            term  = 1'b1;
                        end else begin
                            cnt_d = beats_minus1(owner_burst);
                        end
                    end
                    HTRANS_SEQ:  if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
                    HTRANS_BUSY: cnt_d = cnt_q;
                    default:     cnt_d = '0;
                endcase
                lock_d = owner_lock ? ((owner_trans != HTRANS_IDLE) | locked_q) : 1'b0;
                hold   = lock_d |
                         (!term & ((cnt_d != '0) |
                                   (owner_trans == HTRANS_BUSY) |
                                   ((owner_trans == HTRANS_SEQ) && (owner_burst == HBURST_INCR))));
                rearb  = !hold;
            end
            if (rearb && pick_any) begin
                owner_d = pick_winner;
                lg_d    = pick_winner;
            end
            if (rearb && !pick_any) state_d = ST_IDLE;
            else if (lock_d)        state_d = ST_LOCK;
            else if (cnt_d != '0)   state_d = ST_BURST;
            else                    state_d = ST_OWN;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            cnt_q    <= '0;
            lg_q     <= PORT_W'(NUM_IN - 1);
            dport_q  <= '0;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            lg_q     <= lg_d;
            dport_q  <= dport_d;
            dvalid_q <= dvalid_d;
        end
    end

    assign addr_in_port = owner_q;
    assign no_port      = (state_q == ST_IDLE);
    assign data_in_port = dport_q;
    assign data_valid   = dvalid_q;
    assign dbg_state    = state_q;

    always_comb begin
        active_o = '0;
        for (int i = 0; i < NUM_IN; i++) active_o[i] = ~no_port & (owner_q == PORT_W'(i));
    end

endmodule

// File: tb/tb_ahb_mtx_l2_out_arb.sv
// Bench for ahb_mtx_l2_out_arb: directed scenarios with literal expectations plus a
// per-cycle comparison against a transaction-level ownership model.
module tb_ahb_mtx_l2_out_arb;
    import ahb_mtx_l2_pkg::*;

    localparam int N = 3;
    localparam int W = 11;

    logic           HCLK = 1'b0;
    logic           HRESET;
    logic [N-1:0]   req_i, lock_i;
    logic [2*N-1:0] trans_i;
    logic [3*N-1:0] burst_i;
    logic           HREADYM;

    logic [1:0]   addr_in_port, data_in_port;
    logic         no_port, data_valid;
    logic [N-1:0] active_o;
    arb_state_e   dbg_state;

    logic [1:0]   fix_addr, fix_dport;
    logic         fix_no_port, fix_dvalid;
    logic [N-1:0] fix_active;
    arb_state_e   fix_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];

    ahb_mtx_l2_out_arb #(.NUM_IN(N), .RR_EN(1'b1)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .req_i(req_i), .trans_i(trans_i), .burst_i(burst_i),
        .lock_i(lock_i), .HREADYM(HREADYM), .addr_in_port(addr_in_port), .no_port(no_port),
        .active_o(active_o), .data_in_port(data_in_port), .data_valid(data_valid),
        .dbg_state(dbg_state)
    );

    ahb_mtx_l2_out_arb #(.NUM_IN(N), .RR_EN(1'b0)) u_fix (
        .HCLK(HCLK), .HRESET(HRESET), .req_i(req_i), .trans_i(trans_i), .burst_i(burst_i),
        .lock_i(lock_i), .HREADYM(HREADYM), .addr_in_port(fix_addr), .no_port(fix_no_port),
        .active_o(fix_active), .data_in_port(fix_dport), .data_valid(fix_dvalid),
        .dbg_state(fix_state)
    );

    // clock / reset
    always #5 HCLK = ~HCLK;

    // ownership model: owner -1 means nobody owns the output port
    int m_owner, m_aport, m_left, m_last, m_dport, m_t, m_b, m_w;
    bit m_lock, m_dvalid, m_l, m_early, m_keep;

    function automatic int m_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int burst_len(input int b);
        if (b == 2 || b == 3) return 4;
        if (b == 4 || b == 5) return 8;
        if (b == 6 || b == 7) return 16;
        return 1;
    endfunction

    function automatic logic [W-1:0] m_pack();
        logic [1:0]   st;
        logic [N-1:0] act;
        act = '0;
        if (m_owner < 0)     st = ST_IDLE;
        else if (m_lock)     st = ST_LOCK;
        else if (m_left > 0) st = ST_BURST;
        else                 st = ST_OWN;
        if (m_owner >= 0) act[m_owner] = 1'b1;
        return {st, (m_owner < 0), 2'(m_aport), act, 2'(m_dport), m_dvalid};
    endfunction

    always @(posedge HCLK) begin
        if (HRESET) begin
            m_owner = -1; m_aport = 0; m_left = 0; m_lock = 0;
            m_last = N - 1; m_dport = 0; m_dvalid = 0;
        end else if (HREADYM) begin
            m_dport  = m_aport;
            m_dvalid = 0;
            m_keep   = 0;
            if (m_owner >= 0) begin
                m_t = int'(trans_i[2*m_owner +: 2]);
                m_b = int'(burst_i[3*m_owner +: 3]);
                m_l = lock_i[m_owner];
                m_dvalid = (m_t >= 2);
                m_early = 0;
                if (m_t == 2) begin
                    if (m_left > 0) begin m_left = 0; m_early = 1; end
                    else m_left = burst_len(m_b) - 1;
                end else if (m_t == 3) begin
                    if (m_left > 0) m_left = m_left - 1;
                end else if (m_t == 0) begin
                    m_left = 0;
                end
                if (!m_l) m_lock = 0;
                else if (m_t != 0) m_lock = 1;
                m_keep = m_lock ||
                         (!m_early && (m_left > 0 || m_t == 1 || (m_t == 3 && m_b == 1)));
            end
            if (!m_keep) begin
                m_w = m_pick(req_i, m_last);
                if (m_w < 0) m_owner = -1;
                else begin m_owner = m_w; m_aport = m_w; m_last = m_w; end
            end
        end
        exp_q.push_back(m_pack());
    end

    // scoreboard: every cycle, away from the active edge
    always @(negedge HCLK) begin
        logic [W-1:0] e, a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {dbg_state, no_port, addr_in_port, active_o, data_in_port, data_valid};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL model_cycle t=%0t got %b expected %b (state,no_port,addr,active,dport,dvalid)",
                         $time, a, e);
            end
        end
    end

    // driver tasks
    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input int p, input bit r, input logic [1:0] t,
                         input logic [2:0] b, input bit l);
        req_i[p]          = r;
        trans_i[2*p +: 2] = t;
        burst_i[3*p +: 3] = b;
        lock_i[p]         = l;
    endtask

    task automatic clear_all();
        req_i = '0; trans_i = '0; burst_i = '0; lock_i = '0;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle2();
        clear_all();
        cyc();
        cyc();
    endtask

    initial begin
        HRESET = 1'b1;
        HREADYM = 1'b1;
        clear_all();

        // reset
        cyc(); cyc();
        check("rst_no_port", no_port, 1);
        check("rst_active", active_o, 0);
        check("rst_dvalid", data_valid, 0);
        check("rst_addr", addr_in_port, 0);
        HRESET = 1'b0;
        cyc();
        check("post_rst_idle", no_port, 1);

        // all requesting single transfers: rotation, fixed priority stays on 0
        for (int p = 0; p < N; p++) drive(p, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0);
        cyc();
        check("rr_own_a", addr_in_port, 0);
        check("rr_active_a", active_o, 3'b001);
        check("fix_own_a", fix_addr, 0);
        cyc();
        check("rr_own_b", addr_in_port, 1);
        check("rr_dport_b", data_in_port, 0);
        check("rr_dvalid_b", data_valid, 1);
        cyc();
        check("rr_own_c", addr_in_port, 2);
        cyc();
        check("rr_own_d", addr_in_port, 0);
        check("fix_own_d", fix_addr, 0);
        check("fix_busy_d", fix_no_port, 0);
        clear_all();
        cyc();
        check("rr_release_idle", no_port, 1);
        check("rr_release_dvalid", data_valid, 0);
        cyc();

        // INCR4 on port1, port0 arrives mid-burst
        drive(1, 1, HTRANS_NONSEQ, HBURST_INCR4, 0);
        cyc();
        check("b4_grant", addr_in_port, 1);
        check("b4_active", active_o, 3'b010);
        cyc();
        drive(1, 1, HTRANS_SEQ, HBURST_INCR4, 0);
        cyc();
        drive(0, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0);
        cyc();
        check("b4_hold", addr_in_port, 1);
        check("b4_state", int'(dbg_state), int'(ST_BURST));
        cyc();
        check("b4_switch", addr_in_port, 0);
        check("b4_switch_active", active_o, 3'b001);
        idle2();

        // INCR8 on port2 cut short by IDLE, port0 waiting
        drive(2, 1, HTRANS_NONSEQ, HBURST_INCR8, 0);
        cyc();
        check("b8_grant", addr_in_port, 2);
        cyc();
        drive(2, 1, HTRANS_SEQ, HBURST_INCR8, 0);
        drive(0, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0);
        cyc();
        cyc();
        check("b8_hold", addr_in_port, 2);
        drive(2, 0, HTRANS_IDLE, HBURST_INCR8, 0);
        cyc();
        check("b8_early_switch", addr_in_port, 0);
        check("b8_early_state", int'(dbg_state), int'(ST_OWN));
        check("b8_early_dvalid", data_valid, 0);
        idle2();

        // locked sequence on port0 with others requesting
        drive(0, 1, HTRANS_NONSEQ, HBURST_SINGLE, 1);
        cyc();
        check("lk_grant", addr_in_port, 0);
        drive(1, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0);
        drive(2, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0);
        cyc();
        check("lk_hold1", addr_in_port, 0);
        cyc();
        check("lk_hold2", active_o, 3'b001);
        cyc();
        check("lk_hold3", addr_in_port, 0);
        check("lk_state", int'(dbg_state), int'(ST_LOCK));
        drive(0, 0, HTRANS_IDLE, HBURST_SINGLE, 0);
        cyc();
        check("lk_release", addr_in_port, 1);
        check("lk_release_active", active_o, 3'b010);
        cyc();
        check("lk_next", addr_in_port, 2);
        idle2();

        // stall mid-burst with requests changing underneath
        drive(1, 1, HTRANS_NONSEQ, HBURST_INCR4, 0);
        cyc();
        check("st_grant", addr_in_port, 1);
        cyc();
        drive(1, 1, HTRANS_SEQ, HBURST_INCR4, 0);
        cyc();
        check("st_dport_pre", data_in_port, 1);
        HREADYM = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'($urandom_range(0, 1)), HTRANS_NONSEQ, HBURST_SINGLE, 0);
            drive(2, 1'($urandom_range(0, 1)), HTRANS_NONSEQ, HBURST_SINGLE, 0);
            cyc();
            check("st_addr", addr_in_port, 1);
            check("st_no_port", no_port, 0);
            check("st_active", active_o, 3'b010);
            check("st_dport", data_in_port, 1);
            check("st_dvalid", data_valid, 1);
        end
        HREADYM = 1'b1;
        drive(0, 1, HTRANS_NONSEQ, HBURST_SINGLE, 0);
        drive(2, 0, HTRANS_IDLE, HBURST_SINGLE, 0);
        cyc();
        check("st_resume_hold", addr_in_port, 1);
        cyc();
        check("st_resume_switch", addr_in_port, 0);
        check("st_resume_dport", data_in_port, 1);
        idle2();

        // random mix, checked by the model only
        for (int i = 0; i < 500; i++) begin
            HRESET  = ($urandom_range(0, 79) == 0);
            HREADYM = ($urandom_range(0, 3) != 0);
            for (int p = 0; p < N; p++) begin
                drive(p, 1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)),
                      3'($urandom_range(0, 7)), 1'($urandom_range(0, 7) == 0));
            end
            cyc();
        end
        HRESET = 1'b0;
        HREADYM = 1'b1;
        idle2();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
